fadd_share_arb: RTL and testbench

- Round-robin arbiter that shares one 2-stage pipelined single-precision FP adder among NREQ requesters, such as integer/FP issue ports and the FDIV/FSQRT iteration helpers.
- Accepts at most one request per cycle and drives the adder's x1/x2 inputs. Keeps a tag/valid shift register matched to the adder latency and steers each result back to its originator as a one-cycle pulse.
- Sits between the core's FP issue logic and the shared adder instance. The adder itself is not modified.

---
 rtl/fadd_share_arb.sv | 91 +++++++++
 tb/tb_fadd_share_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fadd_share_arb.sv
// Round-robin front end sharing one pipelined FP adder among NREQ requesters.
// Optional FADD_SHARE_ARB_SUB_EN adds a per-requester subtract select (req_sub).
module fadd_share_arb #(
    parameter  int NREQ = 4,
    parameter  int LAT  = 2,
    localparam int TAGW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_x1,
    input  logic [NREQ*32-1:0]   req_x2,
`ifdef FADD_SHARE_ARB_SUB_EN
    input  logic [NREQ-1:0]      req_sub,
`endif
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          fpu_x1,
    output logic [31:0]          fpu_x2,
    input  logic [31:0]          fpu_y,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_y,
    output logic                 busy
);

    logic [TAGW-1:0]           rr_ptr;
    logic [TAGW-1:0]           gnt;
    logic                      found;
    logic                      xfer;
    int                        idx;
    logic [31:0]               x1_g;
    logic [31:0]               x2_g;
    logic [LAT-1:0]            vld_pipe;
    logic [LAT-1:0][TAGW-1:0]  tag_pipe;

    // Scan from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = TAGW'(idx);
            end
        end
    end

    assign xfer      = found && !rst;
    assign req_ready = xfer ? (NREQ'(1) << gnt) : '0;

    always_comb begin
        x1_g = req_x1[int'(gnt)*32 +: 32];
        x2_g = req_x2[int'(gnt)*32 +: 32];
`ifdef FADD_SHARE_ARB_SUB_EN
        // Flipping the sign of x2 turns the shared add into a subtract.
        x2_g[31] = x2_g[31] ^ req_sub[gnt];
`endif
    end

    assign fpu_x1 = xfer ? x1_g : 32'h0;
    assign fpu_x2 = xfer ? x2_g : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
            resp_valid <= '0;
            resp_y     <= 32'h0;
            busy       <= 1'b0;
        end else begin
            if (xfer)
                rr_ptr <= (gnt == TAGW'(NREQ-1)) ? '0 : gnt + 1'b1;
            vld_pipe[0] <= xfer;
            tag_pipe[0] <= gnt;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            // Last stage lines up with fpu_y; retire it into the response register.
            resp_valid <= vld_pipe[LAT-1] ? (NREQ'(1) << tag_pipe[LAT-1]) : '0;
            if (vld_pipe[LAT-1])
                resp_y <= fpu_y;
            busy <= xfer | (|vld_pipe);
        end
    end

endmodule

// File: tb/tb_fadd_share_arb.sv
// Randomized bench for fadd_share_arb against a queue-based round-robin model
// with a behavioural two-stage adder standing in for the shared FPU.
module tb_fadd_share_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*32-1:0]  req_x1;
    logic [NREQ*32-1:0]  req_x2;
    logic [NREQ-1:0]     req_sub;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         fpu_x1, fpu_x2, fpu_y;
    logic [NREQ-1:0]     resp_valid;
    logic [31:0]         resp_y;
    logic                busy;

    fadd_share_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2),
`ifdef FADD_SHARE_ARB_SUB_EN
        .req_sub(req_sub),
`endif
        .req_ready(req_ready), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
        .resp_valid(resp_valid), .resp_y(resp_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] b;
        if (x[30:0] == 31'h0) return 0.0;
        b = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] b;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return real2sp(sp2real(a) + sp2real(b));
    endfunction

    // Stand-in for the shared adder: two register stages, reset with the arbiter.
    logic [31:0] add_s1;
    always @(posedge clk) begin
        if (rst) begin
            add_s1 <= 32'h0;
            fpu_y  <= 32'h0;
        end else begin
            add_s1 <= fadd(fpu_x1, fpu_x2);
            fpu_y  <= add_s1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    typedef struct { int due; int idx; logic [31:0] y; } pend_t;
    pend_t       q[$];
    int          m_ptr  = 0;
    logic [31:0] m_last = 32'h0;

    // One cycle of the reference: evaluate at negedge, then advance past posedge.
    task automatic cycle();
        int          g;
        logic [31:0] ex1, ex2;
        logic [NREQ-1:0] exp_rv;
        logic        exp_busy;
        @(negedge clk);
        g = -1;
        if (!rst)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        ex1 = 32'h0; ex2 = 32'h0;
        if (g >= 0) begin
            ex1 = req_x1[g*32 +: 32];
            ex2 = req_x2[g*32 +: 32];
`ifdef FADD_SHARE_ARB_SUB_EN
            if (req_sub[g]) ex2[31] = ~ex2[31];
`endif
        end
        chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
        chk("fpu_x1", fpu_x1, ex1);
        chk("fpu_x2", fpu_x2, ex2);
        exp_busy = (q.size() != 0);
        exp_rv = '0;
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_rv = NREQ'(1 << q[0].idx);
            m_last = q[0].y;
            void'(q.pop_front());
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_y", resp_y, m_last);
        chk("busy", 32'(busy), 32'(exp_busy));
        if (rst) begin
            q.delete();
            m_ptr  = 0;
            m_last = 32'h0;
        end else if (g >= 0) begin
            q.push_back('{due: cyc + LAT + 1, idx: g, y: fadd(ex1, ex2)});
            m_ptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_x1[i*32 +: 32] = a;
        req_x2[i*32 +: 32] = b;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_x1 = '0; req_x2 = '0; req_sub = '0;
        @(posedge clk); #1;
        cycle();                       // reset state checks
        rst = 1'b0;
        cycle();

        // Single request: 1.0 + 2.0
        set_req(0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        chk("single_y", resp_y, 32'h40400000);

        // All four held valid for 8 cycles from reset
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, real2sp(real'(i + 1)), real2sp(real'(10 * (i + 1))));
        req_valid = 4'b1111;
        repeat (8) cycle();
        req_valid = '0;
        repeat (4) cycle();

        // Sparse fairness
        req_valid = 4'b0010; cycle();
        req_valid = 4'b0011; repeat (2) cycle();
        req_valid = 4'b1001; repeat (2) cycle();
        req_valid = '0;      repeat (4) cycle();

        // Reset mid-flight, then requester 3 alone
        req_valid = 4'b0011; repeat (2) cycle();
        req_valid = '0; rst = 1'b1; cycle();
        rst = 1'b0;
        req_valid = 4'b1000; cycle();
        req_valid = '0;
        repeat (5) cycle();            // idle: busy falls, resp_y holds

`ifdef FADD_SHARE_ARB_SUB_EN
        set_req(1, 32'h40400000, 32'h3F800000);
        req_sub = 4'b0010; req_valid = 4'b0010; cycle();
        req_valid = '0; req_sub = '0;
        repeat (3) cycle();
        chk("sub_y", resp_y, 32'h40000000);
`endif

        // Random traffic, occasional reset
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_req(i, real2sp(real'($urandom_range(0, 1000))), real2sp(real'($urandom_range(0, 1000))));
            req_sub = NREQ'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0; req_valid = '0;
        repeat (5) cycle();
        chk("drain_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
